console_rx: RTL and testbench

Buffered serial receiver for the console line, taking bytes in from PIN_2 for the CPU. It runs 8N1 with a programmable clock divider and holds incoming bytes in a small FIFO. The CPU side reads with the same data/divider register pulse style the core already uses for console output. A later console-input instruction pulses `dat_re` to pop one byte.

---
 rtl/console_rx_if.sv | 23 ++
 rtl/console_rx.sv | 161 ++++++++++++++++
 tb/tb_console_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/console_rx_if.sv
// CPU-side register bus of the console receiver: divider access, data pop and
// the sticky error flags.
interface console_rx_if;
   logic        div_we;
   logic [31:0] div_di;
   logic [31:0] div_do;
   logic        dat_re;
   logic [31:0] dat_do;
   logic        dat_valid;
   logic        overrun;
   logic        frame_err;
   logic        err_clr;

   modport master (
      output div_we, div_di, dat_re, err_clr,
      input  div_do, dat_do, dat_valid, overrun, frame_err
   );

   modport slave (
      input  div_we, div_di, dat_re, err_clr,
      output div_do, dat_do, dat_valid, overrun, frame_err
   );
endinterface

// File: rtl/console_rx.sv
// 8N1 serial receiver with programmable bit divider and a small byte FIFO that
// the CPU pops one entry at a time.
module console_rx #(
   parameter int unsigned DEFAULT_DIV = 53333,
   parameter int unsigned FIFO_AW     = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ser_rx,
   console_rx_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state, state_next;
   logic          sync1, rxs;
   logic [31:0]   div_reg, bit_div, eff_div, cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          load_start, load_bit, shift_en, push, frame_set;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW:0]   wr_ptr, rd_ptr;
   logic               full, empty, pop, push_ok, ovr_set;
   logic               overrun_q, frame_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= ser_rx;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) div_reg <= DEFAULT_DIV;
      else if (bus.div_we) div_reg <= bus.div_di;
   end

   // Divisors below 2 would leave no room for a mid-bit start sample.
   assign eff_div = (div_reg < 32'd2) ? 32'd2 : div_reg;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_start = 1'b0;
      load_bit   = 1'b0;
      shift_en   = 1'b0;
      push       = 1'b0;
      frame_set  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_next = START;
               load_start = 1'b1;
            end
         end
         START: begin
            if (cnt == 32'd0) begin
               if (rxs) state_next = IDLE;
               else begin
                  state_next = DATA;
                  load_bit   = 1'b1;
               end
            end
         end
         DATA: begin
            if (cnt == 32'd0) begin
               shift_en = 1'b1;
               load_bit = 1'b1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == 32'd0) begin
               if (rxs) begin
                  push       = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_set  = 1'b1;
                  state_next = BREAK;
               end
            end
         end
         BREAK: begin
            if (rxs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_div <= 32'd2;
         cnt     <= 32'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
      end else begin
         if (load_start) begin
            bit_div <= eff_div;
            cnt     <= (eff_div >> 1) - 32'd1;
         end else if (load_bit) begin
            cnt <= bit_div - 32'd1;
         end else if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
         end
         if (state == START) bit_idx <= 3'd0;
         else if (shift_en)  bit_idx <= bit_idx + 3'd1;
         if (shift_en) shreg <= {rxs, shreg[7:1]};
      end
   end

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop     = bus.dat_re && !empty;
   // A simultaneous pop frees the slot a full-FIFO push needs.
   assign push_ok = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (ovr_set)          overrun_q <= 1'b1;
         else if (bus.err_clr) overrun_q <= 1'b0;
         if (frame_set)        frame_err_q <= 1'b1;
         else if (bus.err_clr) frame_err_q <= 1'b0;
      end
   end

   assign bus.div_do    = div_reg;
   assign bus.dat_valid = !empty;
   assign bus.dat_do    = empty ? 32'hFFFF_FFFF : {24'd0, mem[rd_ptr[FIFO_AW-1:0]]};
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_console_rx.sv
// Directed bench for console_rx: frames are driven bit by bit at 16 cycles/bit
// and the register bus is checked against hand-computed values.
module tb_console_rx;

   logic clk;
   logic reset;
   logic ser_rx;
   int   checks;
   int   errors;

   console_rx_if bus();

   console_rx dut (
      .clk    (clk),
      .reset  (reset),
      .ser_rx (ser_rx),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Drives one frame; stop_low>0 holds the stop bit low that many cycles,
   // pop_at_push pulses dat_re in the stop-sample cycle, abort_at>=0 resets mid-frame.
   task automatic applyStimulus(input logic [7:0] data, input int stop_low,
                                input bit pop_at_push, input int abort_at);
      int  total;
      bit  aborted;
      total   = 144 + ((stop_low > 0) ? stop_low : 16);
      aborted = 1'b0;
      for (int k = 0; k < total; k++) begin
         @(negedge clk);
         if (abort_at >= 0 && k == abort_at) begin
            reset   = 1'b1;
            ser_rx  = 1'b1;
            aborted = 1'b1;
            break;
         end
         if (k < 16)       ser_rx = 1'b0;
         else if (k < 144) ser_rx = data[(k - 16) / 16];
         else              ser_rx = (stop_low > 0) ? 1'b0 : 1'b1;
         bus.dat_re = (pop_at_push && k == 154);
      end
      @(negedge clk);
      ser_rx     = 1'b1;
      bus.dat_re = 1'b0;
      if (aborted) begin
         repeat (3) @(negedge clk);
         reset = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic writeDiv(input logic [31:0] v);
      @(negedge clk);
      bus.div_we = 1'b1;
      bus.div_di = v;
      @(negedge clk);
      bus.div_we = 1'b0;
   endtask

   task automatic popByte();
      @(negedge clk);
      bus.dat_re = 1'b1;
      @(negedge clk);
      bus.dat_re = 1'b0;
   endtask

   task automatic clearErr();
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      ser_rx      = 1'b1;
      bus.div_we  = 1'b0;
      bus.div_di  = 32'd0;
      bus.dat_re  = 1'b0;
      bus.err_clr = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset_div", bus.div_do, 32'd53333);
      checkOutput("reset_valid", {31'd0, bus.dat_valid}, 32'd0);
      checkOutput("reset_dat", bus.dat_do, 32'hFFFF_FFFF);
      checkOutput("reset_ovr", {31'd0, bus.overrun}, 32'd0);
      checkOutput("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] two bytes in order");
      writeDiv(32'd16);
      checkOutput("div_wr", bus.div_do, 32'd16);
      applyStimulus(8'h41, 0, 1'b0, -1);
      applyStimulus(8'hA5, 0, 1'b0, -1);
      checkOutput("two_valid", {31'd0, bus.dat_valid}, 32'd1);
      checkOutput("two_first", bus.dat_do, 32'h41);
      popByte();
      checkOutput("two_second", bus.dat_do, 32'hA5);
      popByte();
      checkOutput("two_empty_valid", {31'd0, bus.dat_valid}, 32'd0);
      checkOutput("two_empty_dat", bus.dat_do, 32'hFFFF_FFFF);
      popByte();
      checkOutput("pop_empty_ignored", bus.dat_do, 32'hFFFF_FFFF);

      $display("[TB] glitch rejection");
      @(negedge clk);
      ser_rx = 1'b0;
      repeat (4) @(negedge clk);
      ser_rx = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("glitch_valid", {31'd0, bus.dat_valid}, 32'd0);
      checkOutput("glitch_ferr", {31'd0, bus.frame_err}, 32'd0);
      checkOutput("glitch_ovr", {31'd0, bus.overrun}, 32'd0);
      applyStimulus(8'h3C, 0, 1'b0, -1);
      checkOutput("glitch_next", bus.dat_do, 32'h3C);
      popByte();

      $display("[TB] framing error");
      applyStimulus(8'h00, 40, 1'b0, -1);
      repeat (10) @(negedge clk);
      checkOutput("ferr_set", {31'd0, bus.frame_err}, 32'd1);
      checkOutput("ferr_empty", {31'd0, bus.dat_valid}, 32'd0);
      applyStimulus(8'h33, 0, 1'b0, -1);
      checkOutput("ferr_next", bus.dat_do, 32'h33);
      checkOutput("ferr_sticky", {31'd0, bus.frame_err}, 32'd1);
      clearErr();
      checkOutput("ferr_clr", {31'd0, bus.frame_err}, 32'd0);
      popByte();

      $display("[TB] overrun");
      for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 0, 1'b0, -1);
      checkOutput("ovr_set", {31'd0, bus.overrun}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         checkOutput($sformatf("ovr_head%0d", i), bus.dat_do, 32'(i));
         popByte();
      end
      checkOutput("ovr_drained", {31'd0, bus.dat_valid}, 32'd0);
      clearErr();
      checkOutput("ovr_clr", {31'd0, bus.overrun}, 32'd0);
      for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 0, 1'b0, -1);
      applyStimulus(8'h05, 0, 1'b1, -1);
      checkOutput("pushpop_ovr", {31'd0, bus.overrun}, 32'd0);
      for (int i = 2; i <= 5; i++) begin
         checkOutput($sformatf("pushpop_head%0d", i), bus.dat_do, 32'(i));
         popByte();
      end
      checkOutput("pushpop_drained", {31'd0, bus.dat_valid}, 32'd0);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h55, 0, 1'b0, -1);
      checkOutput("pre_abort_valid", {31'd0, bus.dat_valid}, 32'd1);
      writeDiv(32'd16);
      applyStimulus(8'h7E, 0, 1'b0, 80);
      repeat (200) @(negedge clk);
      checkOutput("abort_valid", {31'd0, bus.dat_valid}, 32'd0);
      checkOutput("abort_dat", bus.dat_do, 32'hFFFF_FFFF);
      checkOutput("abort_div", bus.div_do, 32'd53333);
      checkOutput("abort_ferr", {31'd0, bus.frame_err}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
